// File: rtl/slip_axis_pkg.sv
// Shared definitions for the SLIP AXI-Stream front end.
//   arb_state_e : packet arbiter FSM states
//   idx_width() : bit width needed to index n ports (at least 1)
package slip_axis_pkg;

  typedef enum logic {
    STATE_ARB   = 1'b0,
    STATE_GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// The search starts at the port after i_last_idx and wraps around.
//   i_req      : N request bits
//   i_last_idx : index of the most recent winner
//   o_winner   : first requester found in circular order (valid when o_any)
//   o_any      : at least one request is set
// The request vector is rotated so that bit 0 is the port after
// i_last_idx. The lowest set bit is then found, and the offset is mapped
// back to a port number.
module rr_arbiter
  import slip_axis_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]            i_req,
  input  logic [idx_width(N)-1:0] i_last_idx,
  output logic [idx_width(N)-1:0] o_winner,
  output logic                    o_any
);

  localparam int unsigned W = idx_width(N);

  int unsigned  base;
  logic [N-1:0] rot;
  logic [W-1:0] offset;
  logic         found;

  always_comb begin
    base   = 32'(i_last_idx) + 1;
    rot    = '0;
    offset = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = i_req[W'((base + i) % N)];
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        offset = W'(i);
        found  = 1'b1;
      end
    end
    o_any    = |i_req;
    o_winner = W'((base + 32'(offset)) % N);
  end

endmodule

// File: rtl/slip_axis_packet_arbiter.sv
// Packet-granular round-robin arbiter. It shares one SLIP encoder input
// among NUM_PORTS AXI-S symbol sources.
// A grant is held from the first transfer until a transfer with TLAST.
// After each packet there is one idle (ARB) cycle.
// The granted port index, offset by TID_BASE, is sent as TID.
// When MAX_BURST is non-zero, TLAST is forced on beat number MAX_BURST of
// a grant. The rest of that source's data then goes out as a new packet.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_port_en              per-port enable; a disabled port is never newly granted
//   i_s_axis_*/o_s_axis_*  NUM_PORTS slave streams (tdata packed, port k at [k*W +: W])
//   o_m_axis_*/i_m_axis_*  master stream to the encoder
//   o_grant_valid          a grant is active
//   o_grant_idx            granted port index
module slip_axis_packet_arbiter
  import slip_axis_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned TID_BASE     = 0,
  parameter int unsigned MAX_BURST    = 256,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_PORTS-1:0]              i_port_en,
  input  logic [NUM_PORTS-1:0]              i_s_axis_tvalid,
  output logic [NUM_PORTS-1:0]              o_s_axis_tready,
  input  logic [NUM_PORTS*SYMBOL_WIDTH-1:0] i_s_axis_tdata,
  input  logic [NUM_PORTS-1:0]              i_s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]              i_s_axis_tlast,
  output logic                              o_m_axis_tvalid,
  input  logic                              i_m_axis_tready,
  output logic [SYMBOL_WIDTH-1:0]           o_m_axis_tdata,
  output logic                              o_m_axis_tkeep,
  output logic                              o_m_axis_tlast,
  output logic [SYMBOL_WIDTH-1:0]           o_m_axis_tid,
  output logic                              o_grant_valid,
  output logic [idx_width(NUM_PORTS)-1:0]   o_grant_idx
);

  localparam int unsigned           IDX_W      = idx_width(NUM_PORTS);
  localparam logic                  LIMIT_EN   = (MAX_BURST != 0);
  localparam logic [CNT_WIDTH-1:0]  BURST_LAST = CNT_WIDTH'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

  logic [NUM_PORTS-1:0]    arb_req;
  logic [IDX_W-1:0]        arb_winner;
  logic                    arb_any;
  logic [SYMBOL_WIDTH-1:0] tdata_arr [NUM_PORTS];
  logic                    force_last;

  assign arb_req = i_s_axis_tvalid & i_port_en;

  rr_arbiter #(
    .N (NUM_PORTS)
  ) u_rr_arbiter (
    .i_req      (arb_req),
    .i_last_idx (last_idx_q),
    .o_winner   (arb_winner),
    .o_any      (arb_any)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      tdata_arr[k] = i_s_axis_tdata[k*SYMBOL_WIDTH +: SYMBOL_WIDTH];
    end
  end

  assign force_last = LIMIT_EN && (burst_cnt_q == BURST_LAST);

  // The data path is muxed from grant_idx_q in both states, and that index
  // changes only on a handshake. So data, keep, last and id stay stable
  // during backpressure. Only tvalid/tready are gated by the state.
  always_comb begin
    state_d         = state_q;
    grant_idx_d     = grant_idx_q;
    last_idx_d      = last_idx_q;
    burst_cnt_d     = burst_cnt_q;
    o_m_axis_tvalid = 1'b0;
    o_s_axis_tready = '0;
    o_m_axis_tdata  = tdata_arr[grant_idx_q];
    o_m_axis_tkeep  = i_s_axis_tkeep[grant_idx_q];
    o_m_axis_tlast  = i_s_axis_tlast[grant_idx_q] | force_last;
    o_m_axis_tid    = SYMBOL_WIDTH'(TID_BASE) + SYMBOL_WIDTH'(grant_idx_q);

    unique case (state_q)
      STATE_ARB: begin
        if (arb_any) begin
          grant_idx_d = arb_winner;
          last_idx_d  = arb_winner;
          burst_cnt_d = '0;
          state_d     = STATE_GRANT;
        end
      end
      STATE_GRANT: begin
        o_m_axis_tvalid              = i_s_axis_tvalid[grant_idx_q];
        o_s_axis_tready[grant_idx_q] = i_m_axis_tready;
        if (i_s_axis_tvalid[grant_idx_q] && i_m_axis_tready) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (o_m_axis_tlast) begin
            state_d = STATE_ARB;
          end
        end
      end
      default: state_d = STATE_ARB;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= STATE_ARB;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_W'(NUM_PORTS - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign o_grant_valid = (state_q == STATE_GRANT);
  assign o_grant_idx   = grant_idx_q;

endmodule

// File: doc/slip_axis_packet_arbiter.md
Name: slip_axis_packet_arbiter

Overview:
Packet-granular round-robin arbiter that shares one slip_axis_encoder input among NUM_PORTS AXI-S symbol sources. A grant is held from the first transfer to TLAST, so the encoder never sees interleaved TIDs. Each source's port index becomes TID, offset by TID_BASE. A burst limiter forces TLAST so one source cannot starve the others.

Parameters:
NUM_PORTS, 4, number of requesting AXI-S sources (2..16)
SYMBOL_WIDTH, 8, TDATA/TID width
TID_BASE, 0, TID emitted for port 0; port k emits TID_BASE+k (mod 2^SYMBOL_WIDTH)
MAX_BURST, 256, max transfers per grant; 0 = unlimited
CNT_WIDTH, 16, burst counter width; must satisfy MAX_BURST < 2^CNT_WIDTH

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-high
i_port_en  in  NUM_PORTS  per-port enable; a masked port is never newly granted
i_s_axis_tvalid  in  NUM_PORTS  per-port TVALID
o_s_axis_tready  out  NUM_PORTS  per-port TREADY
i_s_axis_tdata  in  NUM_PORTS*SYMBOL_WIDTH  packed TDATA; port k at [k*W +: W]
i_s_axis_tkeep  in  NUM_PORTS  per-port TKEEP
i_s_axis_tlast  in  NUM_PORTS  per-port TLAST
o_m_axis_tvalid  out  1  to encoder
i_m_axis_tready  in  1  from encoder
o_m_axis_tdata  out  SYMBOL_WIDTH  muxed TDATA
o_m_axis_tkeep  out  1  muxed TKEEP
o_m_axis_tlast  out  1  muxed TLAST, OR forced by burst limit
o_m_axis_tid  out  SYMBOL_WIDTH  TID_BASE + granted index
o_grant_valid  out  1  status: a grant is active
o_grant_idx  out  clog2(NUM_PORTS)  status: granted port index

Behaviour:
- Reset values: state=ARB, grant_idx=0, last_idx=NUM_PORTS-1 (port 0 has first priority), burst_cnt=0. o_m_axis_tvalid=0 and o_s_axis_tready=0 during reset.
- State ARB:
  - req = i_s_axis_tvalid & i_port_en.
  - If req != 0: pick the first set bit searching circularly from last_idx+1. Register grant_idx=last_idx=winner, burst_cnt=0, go to GRANT.
  - No handshakes occur in ARB. Outputs: m_tvalid=0, all s_tready=0.
- State GRANT: combinational pass-through of granted port g, zero added latency.
  - m_tvalid=s_tvalid[g]; s_tready[g]=i_m_axis_tready; all other s_tready=0.
  - m_tdata/tkeep come from port g; m_tid=TID_BASE+g.
  - m_tlast = s_tlast[g] | force, where force = (MAX_BURST!=0) && (burst_cnt==MAX_BURST-1).
- On each handshake (m_tvalid && i_m_axis_tready) in GRANT:
  - burst_cnt++.
  - If m_tlast=1: go to ARB. This gives one bubble cycle between packets.
- Grant is sticky: s_tvalid[g] dropping mid-packet, or i_port_en[g] going low, does not revoke the grant. The arbiter waits for the transfer with TLAST.
- Forced TLAST counts toward the limit regardless of TKEEP. The source's remaining data continues as a new packet with the same TID once that port is re-granted.
- Fairness: after port k finishes, ports k+1..N-1, 0..k are checked in that order. A lone requester is re-granted after a single ARB cycle.
- Outputs are stable while m_tvalid=1 && !i_m_axis_tready, because g and burst_cnt change only on a handshake.
- Reset mid-packet: immediate return to ARB with reset values. The partial packet is abandoned; the encoder, sharing the same reset, re-emits END.
- o_grant_valid = (state==GRANT); o_grant_idx = grant_idx.

Decomposition:
- Package slip_axis_pkg: state encodings STATE_ARB/STATE_GRANT and the clog2 index-width helper.
- Sub-module rr_arbiter (parameter N): inputs req and last_idx; outputs winner index and any. Purely combinational rotate / priority-encode / unrotate, so it can be reused by the later TX-mux.
- Top level holds the FSM, counters and muxes.

Test Plan:
1. Port0 sends a 3-symbol packet 0x11,0x22,0x33(TLAST), sink always ready -> m_tid=0 on all 3 beats; m_tvalid low for one cycle after the TLAST beat.
2. Ports 1 and 2 each stream 2-beat packets continuously -> grants alternate 1,2,1,2. TIDs 0x01/0x02 (TID_BASE=0) never interleave within a packet.
3. MAX_BURST=4, port3 sends 10 beats with TLAST only on beat 10 -> m_tlast=1 on output beats 4, 8 and 10. Port0, requesting since beat 2, is granted after beat 4.
4. Sink backpressure: i_m_axis_tready low for 5 cycles mid-packet while port0 holds 0xC0 -> m_tdata=0xC0 and m_tvalid=1 held stable; o_s_axis_tready[0]=0 throughout.
5. Port1 deasserts TVALID for 3 cycles mid-packet while port2 requests -> grant stays on 1 (o_grant_idx=1) until port1's TLAST beat.
6. i_port_en=4'b1101 with all ports requesting -> port1 is never granted. Assert i_rst mid-packet -> next cycle m_tvalid=0 and o_grant_valid=0; the first grant after release goes to port0.
